// File: rtl/regfile_test_pkg.sv
// Shared definitions for the register-file tester: pattern modes, FSM states
// and a constant-foldable ceil(log2) helper.
package regfile_test_pkg;

    localparam logic [1:0] MODE_ADDR    = 2'b00;
    localparam logic [1:0] MODE_CHECKER = 2'b01;
    localparam logic [1:0] MODE_WALK    = 2'b10;
    localparam logic [1:0] MODE_INV     = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pattern_gen.sv
// Combinational test-pattern generator: maps (mode, address) to write data.
module pattern_gen
    import regfile_test_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  data
);

    logic [WIDTH-1:0] w_addr_ext;
    logic [WIDTH-1:0] w_checker;
    logic [WIDTH-1:0] w_walk;

    always_comb begin
        w_addr_ext = WIDTH'(address);
        // Even addresses get 0101.. (bit 0 set), odd addresses the complement.
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_checker[i] = (i % 2 == 0) ^ address[0];
        end
        w_walk = WIDTH'(1) << (32'(address) % WIDTH);
        case (mode)
            MODE_ADDR:    data = w_addr_ext;
            MODE_CHECKER: data = w_checker;
            MODE_WALK:    data = w_walk;
            MODE_INV:     data = ~w_addr_ext;
            default:      data = '0;
        endcase
    end

endmodule

// File: rtl/regfile_tester.sv
// Built-in tester for a register file: writes a pattern to every address,
// reads it back through a latency-matched delay line and counts mismatches.
module regfile_tester
    import regfile_test_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RD_LAT  = 0,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  qout,
    output logic [WIDTH-1:0]  dbus,
    output logic [ADDR_W-1:0] address,
    output logic              rwb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int unsigned STAGES = RD_LAT + 1;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_dbus;
    logic              r_rwb;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [7:0]        r_err_cnt;
    logic [ADDR_W-1:0] r_err_adr;
    logic [RD_LAT:0]   r_vld;
    logic [WIDTH-1:0]  r_exp [STAGES];
    logic [ADDR_W-1:0] r_tag [STAGES];

    state_t            w_state_nxt;
    logic [1:0]        w_mode_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_start_acc;
    logic              w_last;
    logic              w_pending;
    logic [WIDTH-1:0]  w_pat;
    logic              w_issue;
    logic              w_rwb_nxt;
    logic [WIDTH-1:0]  w_dbus_nxt;
    logic              w_mis;
    logic [7:0]        w_cnt_base;
    logic [ADDR_W-1:0] w_adr_base;
    logic [7:0]        w_err_cnt_nxt;
    logic [ADDR_W-1:0] w_err_adr_nxt;
    logic              w_pass_nxt;

    pattern_gen #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_pattern_gen (
        .mode    (w_mode_nxt),
        .address (w_addr_nxt),
        .data    (w_pat)
    );

    assign w_last = (r_addr == ADDR_W'(DEPTH - 1));

    // Next-state, address sequencing and mode latch.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_addr_nxt  = r_addr;
        w_start_acc = 1'b0;
        w_pending   = 1'b0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_pending = w_pending | r_vld[i];
        end
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_addr_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_WRITE;
                    w_mode_nxt  = mode;
                    w_start_acc = 1'b1;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
                    w_state_nxt = ST_READ;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            ST_READ: begin
                if (w_last) begin
                    w_state_nxt = (RD_LAT > 0) ? ST_DRAIN : ST_DONE;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                w_addr_nxt = '0;
                if (!w_pending) w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_addr_nxt  = '0;
            end
        endcase
    end

    // Bus data, compare and error bookkeeping for the coming edge.
    always_comb begin
        w_issue    = (w_state_nxt == ST_READ);
        w_rwb_nxt  = (w_state_nxt == ST_WRITE);
        w_dbus_nxt = w_rwb_nxt ? w_pat : '0;
        w_cnt_base = w_start_acc ? 8'd0 : r_err_cnt;
        w_adr_base = w_start_acc ? '0 : r_err_adr;
        w_mis      = r_vld[RD_LAT] && (qout != r_exp[RD_LAT]);
        w_err_cnt_nxt = w_cnt_base;
        w_err_adr_nxt = w_adr_base;
        if (w_mis) begin
            if (w_cnt_base == 8'd0) w_err_adr_nxt = r_tag[RD_LAT];
            if (w_cnt_base != 8'd255) w_err_cnt_nxt = w_cnt_base + 8'd1;
        end
        if (w_state_nxt != ST_DONE) begin
            w_pass_nxt = 1'b0;
        end else if (r_state == ST_DONE) begin
            w_pass_nxt = r_pass;
        end else begin
            w_pass_nxt = (w_err_cnt_nxt == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= '0;
            r_addr    <= '0;
            r_dbus    <= '0;
            r_rwb     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_err_adr <= '0;
            r_vld     <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                r_exp[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_addr    <= w_addr_nxt;
            r_dbus    <= w_dbus_nxt;
            r_rwb     <= w_rwb_nxt;
            r_busy    <= (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ) ||
                         (w_state_nxt == ST_DRAIN);
            r_done    <= (w_state_nxt == ST_DONE);
            r_pass    <= w_pass_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_err_adr <= w_err_adr_nxt;
            r_vld[0]  <= w_issue;
            r_exp[0]  <= w_pat;
            r_tag[0]  <= w_addr_nxt;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_exp[i] <= r_exp[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign dbus      = r_dbus;
    assign address   = r_addr;
    assign rwb       = r_rwb;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_cnt;
    assign err_addr  = r_err_adr;

endmodule

// File: tb/tb_regfile_tester.sv
// Bench for regfile_tester: three configurations, each paired with a small
// register-file model (ideal/stuck-bit, two-cycle latency, all-zero).
module tb_regfile_tester;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // ---------------- u0: WIDTH=4 DEPTH=4 RD_LAT=0 ----------------
    logic       start0;
    logic [1:0] mode0;
    logic [3:0] qout0, dbus0;
    logic [1:0] addr0, eadr0;
    logic       rwb0, busy0, done0, pass0;
    logic [7:0] ecnt0;
    logic       fault0;
    logic [3:0] mem0 [4];

    regfile_tester #(.WIDTH(4), .DEPTH(4), .RD_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .qout(qout0),
        .dbus(dbus0), .address(addr0), .rwb(rwb0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(ecnt0), .err_addr(eadr0)
    );

    always @(posedge clk) begin
        if (rwb0) mem0[addr0] <= (fault0 && addr0 == 2'd2) ? (dbus0 | 4'b0001) : dbus0;
    end
    assign qout0 = mem0[addr0];

    // ---------------- u1: WIDTH=4 DEPTH=8 RD_LAT=2 ----------------
    logic       start1;
    logic [1:0] mode1;
    logic [3:0] qout1, dbus1, p1, p2;
    logic [2:0] addr1, eadr1;
    logic       rwb1, busy1, done1, pass1;
    logic [7:0] ecnt1;
    logic [3:0] mem1 [8];

    regfile_tester #(.WIDTH(4), .DEPTH(8), .RD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .qout(qout1),
        .dbus(dbus1), .address(addr1), .rwb(rwb1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ecnt1), .err_addr(eadr1)
    );

    always @(posedge clk) begin
        if (rwb1) mem1[addr1] <= dbus1;
        p1 <= mem1[addr1];
        p2 <= p1;
    end
    assign qout1 = p2;

    // ---------------- u2: WIDTH=8 DEPTH=256 RD_LAT=0, all-zero model ----------------
    logic       start2;
    logic [1:0] mode2;
    logic [7:0] qout2, dbus2;
    logic [7:0] addr2, eadr2;
    logic       rwb2, busy2, done2, pass2;
    logic [7:0] ecnt2;

    regfile_tester #(.WIDTH(8), .DEPTH(256), .RD_LAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .qout(qout2),
        .dbus(dbus2), .address(addr2), .rwb(rwb2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(ecnt2), .err_addr(eadr2)
    );
    assign qout2 = 8'h00;

    typedef struct {
        logic [1:0]  mode;
        logic        fault;
        logic [15:0] wr;      // write data, address i in wr[4*i +: 4]
        logic        pass;
        logic [7:0]  cnt;
        logic [1:0]  eadr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic wait_done(input int sel, input int from_e, input int limit, output int got);
        logic d;
        got = -1;
        for (int e = from_e; e <= limit; e++) begin
            @(posedge clk); #1;
            d = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
            if (d) begin
                got = e;
                break;
            end
        end
    endtask

    // One full pass on u0, start sampled at edge 0.
    task automatic run0(input vec_t v, input int tag);
        int got;
        @(negedge clk);
        fault0 = v.fault;
        mode0  = v.mode;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("busy_e0", tag, 32'(busy0), 32'd1);
        chk("done_e0", tag, 32'(done0), 32'd0);
        chk("rwb_e0",  tag, 32'(rwb0),  32'd1);
        chk("addr_e0", tag, 32'(addr0), 32'd0);
        chk("wr0",     tag, 32'(dbus0), 32'(v.wr[3:0]));
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("addr_w", tag, 32'(addr0), 32'(i));
            chk("wr",     tag, 32'(dbus0), 32'(v.wr[4*i +: 4]));
        end
        @(posedge clk); #1;
        chk("rwb_rd",  tag, 32'(rwb0),  32'd0);
        chk("dbus_rd", tag, 32'(dbus0), 32'd0);
        wait_done(0, 5, 20, got);
        chk("done_edge", tag, 32'(got),   32'd8);
        chk("pass",      tag, 32'(pass0), 32'(v.pass));
        chk("err_count", tag, 32'(ecnt0), 32'(v.cnt));
        chk("err_addr",  tag, 32'(eadr0), 32'(v.eadr));
        chk("busy_done", tag, 32'(busy0), 32'd0);
    endtask

    initial begin
        int got;
        n_chk  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0  = 2'b00; mode1 = 2'b00; mode2 = 2'b00;
        fault0 = 1'b0;

        vecs[0] = '{mode: 2'b00, fault: 1'b0, wr: 16'h3210, pass: 1'b1, cnt: 8'd0, eadr: 2'd0};
        vecs[1] = '{mode: 2'b01, fault: 1'b0, wr: 16'hA5A5, pass: 1'b1, cnt: 8'd0, eadr: 2'd0};
        vecs[2] = '{mode: 2'b10, fault: 1'b0, wr: 16'h8421, pass: 1'b1, cnt: 8'd0, eadr: 2'd0};
        vecs[3] = '{mode: 2'b11, fault: 1'b1, wr: 16'hCDEF, pass: 1'b1, cnt: 8'd0, eadr: 2'd0};
        vecs[4] = '{mode: 2'b00, fault: 1'b1, wr: 16'h3210, pass: 1'b0, cnt: 8'd1, eadr: 2'd2};
        vecs[5] = '{mode: 2'b01, fault: 1'b1, wr: 16'hA5A5, pass: 1'b1, cnt: 8'd0, eadr: 2'd0};
        vecs[6] = '{mode: 2'b10, fault: 1'b1, wr: 16'h8421, pass: 1'b0, cnt: 8'd1, eadr: 2'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dbus", 0, 32'(dbus0), 32'd0);
        chk("rst_addr", 0, 32'(addr0), 32'd0);
        chk("rst_rwb",  0, 32'(rwb0),  32'd0);
        chk("rst_busy", 0, 32'(busy0), 32'd0);
        chk("rst_done", 0, 32'(done0), 32'd0);
        chk("rst_pass", 0, 32'(pass0), 32'd0);
        chk("rst_ecnt", 0, 32'(ecnt0), 32'd0);
        chk("rst_eadr", 0, 32'(eadr0), 32'd0);
        chk("rst_done1", 0, 32'(done1), 32'd0);
        chk("rst_busy2", 0, 32'(busy2), 32'd0);
        rst_n = 1'b1;

        // Table: first pass starts from IDLE, the rest restart from DONE
        for (int k = 0; k < 7; k++) run0(vecs[k], k);

        // Reset at edge 3, mid-WRITE
        @(negedge clk);
        fault0 = 1'b0; mode0 = 2'b11; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mw_dbus", 0, 32'(dbus0), 32'd0);
        chk("mw_addr", 0, 32'(addr0), 32'd0);
        chk("mw_rwb",  0, 32'(rwb0),  32'd0);
        chk("mw_busy", 0, 32'(busy0), 32'd0);
        chk("mw_done", 0, 32'(done0), 32'd0);
        chk("mw_pass", 0, 32'(pass0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mw_idle", 0, 32'(busy0), 32'd0);
        run0(vecs[0], 10);

        // Reset at edge 7 while the faulty address 2 is in flight
        @(negedge clk);
        fault0 = 1'b1; mode0 = 2'b00; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mr_ecnt7", 0, 32'(ecnt0), 32'd0);
        rst_n = 1'b1;
        for (int e = 8; e < 10; e++) begin
            @(posedge clk); #1;
            chk("mr_ecnt", e, 32'(ecnt0), 32'd0);
            chk("mr_done", e, 32'(done0), 32'd0);
            chk("mr_busy", e, 32'(busy0), 32'd0);
        end

        // RD_LAT=2 DEPTH=8: start at edge 0, ignored start at edge 5, done at 18
        @(negedge clk);
        mode1 = 2'b00; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start1 = 1'b1; mode1 = 2'b11;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("l2_addr5", 0, 32'(addr1), 32'd5);
        chk("l2_rwb5",  0, 32'(rwb1),  32'd1);
        chk("l2_dbus5", 0, 32'(dbus1), 32'd5);
        wait_done(1, 6, 40, got);
        chk("l2_done_edge", 0, 32'(got),   32'd18);
        chk("l2_pass",      0, 32'(pass1), 32'd1);
        chk("l2_ecnt",      0, 32'(ecnt1), 32'd0);
        chk("l2_busy",      0, 32'(busy1), 32'd0);

        // DEPTH=256 all-zero model, walking one: saturation
        @(negedge clk);
        mode2 = 2'b10; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("sat_dbus0", 0, 32'(dbus2), 32'h01);
        wait_done(2, 1, 600, got);
        chk("sat_done_edge", 0, 32'(got),   32'd512);
        chk("sat_ecnt",      0, 32'(ecnt2), 32'd255);
        chk("sat_eadr",      0, 32'(eadr2), 32'd0);
        chk("sat_pass",      0, 32'(pass2), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
